// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store enables/replication, load extraction/extension, alignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        byte_sel   = rdata[7:0];
        half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sext       = ~funct3[2];
        be         = 4'b1111;
        wdata      = wdata_in;
        load_data  = rdata;
        misaligned = 1'b0;

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        // funct3[1:0] is the access width; funct3[2] selects zero-extension
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{wdata_in[7:0]}};
                load_data = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{wdata_in[15:0]}};
                load_data  = {{16{sext & half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            default: begin
                be         = 4'b1111;
                wdata      = wdata_in;
                load_data  = rdata;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: issues one data-memory access per load/store and stalls the core until it completes.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             fault_q;
    logic [2:0]       f3_q;
    logic [1:0]       lo_q;

    logic [2:0]  sel_f3;
    logic [1:0]  sel_lo;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        misaligned;
    logic        op;
    logic        f3_ok;
    logic        illegal;

    // While busy, extract load data with the issued width/offset rather than live inputs
    assign sel_f3 = (state == IDLE) ? funct3    : f3_q;
    assign sel_lo = (state == IDLE) ? Addr[1:0] : lo_q;

    lsu_align u_align (
        .funct3     (sel_f3),
        .addr_lo    (sel_lo),
        .wdata_in   (WriteData),
        .rdata      (dmem_rdata),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    always_comb begin
        f3_ok = 1'b0;
        if (MemWrite) f3_ok = funct3 inside {F3_B, F3_H, F3_W};
        else          f3_ok = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    end

    assign op      = MemRead | MemWrite;
    assign illegal = (MemRead & MemWrite) | ~f3_ok | misaligned;
    assign Stall   = ((state == IDLE) & op & ~illegal) | (state == BUSY);
    assign Fault   = ((state == IDLE) & op & illegal) | ((state == DONE) & fault_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            fault_q    <= 1'b0;
            f3_q       <= '0;
            lo_q       <= '0;
            ReadData   <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op && !illegal) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite;
                        dmem_addr  <= {Addr[31:2], 2'b00};
                        dmem_be    <= be;
                        dmem_wdata <= wdata;
                        f3_q       <= funct3;
                        lo_q       <= Addr[1:0];
                        cnt        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    // An ack on the final allowed cycle still wins over the timeout
                    if (dmem_ack) begin
                        if (!dmem_we) ReadData <= load_data;
                        dmem_req <= 1'b0;
                        state    <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        dmem_req <= 1'b0;
                        fault_q  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    fault_q <= 1'b0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
